// File: rtl/ud_cnt_mod.sv
// Parametrised up/down counter with modulo limit, step size, wrap/saturate mode,
// clear/load controls and boundary-event flags.
module ud_cnt_mod #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter int              STEP_W   = 4,
  parameter bit              SAT_MODE = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_ld_val,
  input  logic              i_en,
  input  logic              i_ud,
  input  logic [STEP_W-1:0] i_step,
  output logic [WIDTH-1:0]  o_cnt,
  output logic              o_evt,
  output logic              o_ovf,
  output logic              o_udf,
  output logic              o_at_max,
  output logic              o_at_min
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] ld_clamped;
  logic             up_carry;
  logic [WIDTH-1:0] up_lo;
  logic             up_over;
  logic [WIDTH-1:0] up_wrap;
  logic             dn_under;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] dn_wrap;

  assign step_w     = WIDTH'(i_step);
  assign ld_clamped = (i_ld_val > MAX_VAL) ? MAX_VAL : i_ld_val;

  // The carry is the extra bit of the WIDTH+1 sum; the wrapped results fit in WIDTH bits.
  assign {up_carry, up_lo} = {1'b0, cnt_q} + {1'b0, step_w};
  assign up_over  = up_carry | (up_lo > MAX_VAL);
  assign up_wrap  = up_lo - MAX_VAL - ONE_W;
  assign dn_under = step_w > cnt_q;
  assign dn_diff  = cnt_q - step_w;
  assign dn_wrap  = MAX_VAL - (step_w - cnt_q - ONE_W);

  always_comb begin
    cnt_d = cnt_q;
    evt_d = 1'b0;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (i_clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (i_load) begin
      cnt_d = ld_clamped;
    end else if (i_en) begin
      if (i_ud) begin
        if (up_over) begin
          evt_d = 1'b1;
          ovf_d = 1'b1;
          cnt_d = SAT_MODE ? MAX_VAL : up_wrap;
        end else begin
          cnt_d = up_lo;
        end
      end else begin
        if (dn_under) begin
          evt_d = 1'b1;
          udf_d = 1'b1;
          cnt_d = SAT_MODE ? '0 : dn_wrap;
        end else begin
          cnt_d = dn_diff;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      evt_q <= evt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_cnt    = cnt_q;
  assign o_evt    = evt_q;
  assign o_ovf    = ovf_q;
  assign o_udf    = udf_q;
  assign o_at_max = (cnt_q == MAX_VAL);
  assign o_at_min = (cnt_q == '0);

endmodule
